// File: rtl/issue_div_fifo.sv
// rtl/issue_div_fifo.sv - show-ahead FIFO between issue div-path selector and execute_div; optional ISSUE_DIV_FIFO_EMPTY_BYPASS_EN
package issue_div_fifo_pkg;

    typedef struct packed {
        logic        valid;
        logic [6:0]  rob_id;
        logic [1:0]  div_op;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
    } issue_execute_pack_t;

    typedef struct packed {
        logic enable;
        logic flush;
    } commit_feedback_pack_t;

endpackage

module issue_div_fifo
    import issue_div_fifo_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  issue_execute_pack_t   issue_div_fifo_data_in,
    input  logic                  issue_div_fifo_push,
    output logic                  issue_div_fifo_full,
    output issue_execute_pack_t   issue_div_fifo_data_out,
    output logic                  issue_div_fifo_data_out_valid,
    input  logic                  issue_div_fifo_pop,
    output logic [CNT_W-1:0]      issue_div_fifo_count,
    input  commit_feedback_pack_t commit_feedback_pack
);

    localparam int AW = $clog2(DEPTH);

    issue_execute_pack_t mem_q [DEPTH];
    logic [CNT_W-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0]    wptr_q, wptr_d;
    logic [CNT_W-1:0]    count;
    logic                empty;
    logic                flush;
    logic                push_acc;
    logic                pop_acc;

    // Occupancy and flags derive only from registered pointers, so push never sees a same-cycle pop.
    always_comb begin
        count = wptr_q - rptr_q;
        empty = (count == '0);
        flush = commit_feedback_pack.enable & commit_feedback_pack.flush;
    end

`ifdef ISSUE_DIV_FIFO_EMPTY_BYPASS_EN
    logic bypass;
    logic bypass_consume;

    // Empty FIFO forwards the incoming entry; if popped in the same cycle it is never stored.
    always_comb begin
        bypass                        = empty & issue_div_fifo_push & ~flush;
        bypass_consume                = bypass & issue_div_fifo_pop;
        issue_div_fifo_data_out       = bypass ? issue_div_fifo_data_in : mem_q[rptr_q[AW-1:0]];
        issue_div_fifo_data_out_valid = ~empty | bypass;
        push_acc = issue_div_fifo_push & ~issue_div_fifo_full & ~flush & ~bypass_consume;
        pop_acc  = issue_div_fifo_pop & ~empty & ~flush;
    end
`else
    // Head entry is shown straight from storage; no path from data_in or push to outputs.
    always_comb begin
        issue_div_fifo_data_out       = mem_q[rptr_q[AW-1:0]];
        issue_div_fifo_data_out_valid = ~empty;
        push_acc = issue_div_fifo_push & ~issue_div_fifo_full & ~flush;
        pop_acc  = issue_div_fifo_pop & ~empty & ~flush;
    end
`endif

    // Status outputs.
    always_comb begin
        issue_div_fifo_full  = (count == CNT_W'(DEPTH));
        issue_div_fifo_count = count;
    end

    // Pointer next state: flush wins over push/pop; wrap bit toggles naturally on overflow.
    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        if (flush) begin
            rptr_d = '0;
            wptr_d = '0;
        end else begin
            if (push_acc) wptr_d = wptr_q + 1'b1;
            if (pop_acc)  rptr_d = rptr_q + 1'b1;
        end
    end

    // Pointer registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wptr_q[AW-1:0]] <= issue_div_fifo_data_in;
    end

endmodule

// File: tb/tb_issue_div_fifo.sv
// tb/tb_issue_div_fifo.sv - scoreboard bench for issue_div_fifo
module tb_issue_div_fifo;
    import issue_div_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    issue_execute_pack_t   data_in;
    logic                  push_i;
    logic                  full_o;
    issue_execute_pack_t   data_out;
    logic                  valid_o;
    logic                  pop_i;
    logic [CNT_W-1:0]      count_o;
    commit_feedback_pack_t cfp;

    int n_cmp  = 0;
    int n_fail = 0;
    int model_cnt = 0;
    int exp_q[$];

    issue_div_fifo #(.DEPTH(DEPTH)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .issue_div_fifo_data_in        (data_in),
        .issue_div_fifo_push           (push_i),
        .issue_div_fifo_full           (full_o),
        .issue_div_fifo_data_out       (data_out),
        .issue_div_fifo_data_out_valid (valid_o),
        .issue_div_fifo_pop            (pop_i),
        .issue_div_fifo_count          (count_o),
        .commit_feedback_pack          (cfp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must present the oldest outstanding expected entry.
    always @(negedge clk) begin
        if (!rst && pop_i && valid_o && !(cfp.enable && cfp.flush)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mon_unexpected: got rob_id %0d expected no entry", data_out.rob_id);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(data_out.rob_id) != e) begin
                    n_fail++;
                    $display("FAIL mon_rob_id: got %0d expected %0d", data_out.rob_id, e);
                end
            end
        end
    end

    logic byp_now;

    task automatic drive(input bit push, input int rob, input bit pop, input bit flush);
        data_in           = '0;
        data_in.valid     = push;
        data_in.rob_id    = 7'(rob);
        data_in.rs1_value = 32'(rob * 3);
        data_in.rs2_value = 32'(rob + 1);
        push_i     = push;
        pop_i      = pop;
        cfp.enable = flush;
        cfp.flush  = flush;
        byp_now    = 1'b0;
`ifdef ISSUE_DIV_FIFO_EMPTY_BYPASS_EN
        byp_now = push && pop && !flush && model_cnt == 0;
`endif
        if (!flush && push && model_cnt < DEPTH) exp_q.push_back(rob);
    endtask

    task automatic commit();
        if (cfp.enable && cfp.flush) begin
            model_cnt = 0;
            exp_q.delete();
        end else if (!byp_now) begin
            if (push_i && model_cnt < DEPTH) model_cnt++;
            if (pop_i && model_cnt > 0 && !(push_i && model_cnt == 1 && 0)) begin
            end
        end
        #1;
        push_i = 1'b0; pop_i = 1'b0; cfp = '0; data_in = '0;
    endtask

    // Pop accounting is done against the pre-edge count, so it is captured before commit.
    task automatic step(input bit push, input int rob, input bit pop, input bit flush);
        int pre;
        pre = model_cnt;
        drive(push, rob, pop, flush);
        @(posedge clk);
        commit();
        if (!flush && !byp_now && pop && pre > 0) model_cnt--;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        push_i = 1'b0; pop_i = 1'b0; cfp = '0; data_in = '0; byp_now = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("idle_count", int'(count_o), 0);
            check("idle_valid", int'(valid_o), 0);
            check("idle_full",  int'(full_o),  0);
        end

        // Fill to full, overflow push dropped, drain in order.
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, i, 1'b0, 1'b0);
            check("fill_count", int'(count_o), i);
        end
        check("fill_full", int'(full_o), 1);
        step(1'b1, 5, 1'b0, 1'b0);
        check("ovf_count", int'(count_o), 4);
        check("ovf_full",  int'(full_o),  1);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0);
        check("drain_valid", int'(valid_o), 0);
        check("drain_count", int'(count_o), 0);

        // Steady state push+pop at count 2 across pointer wrap.
        step(1'b1, 10, 1'b0, 1'b0);
        step(1'b1, 11, 1'b0, 1'b0);
        check("pp_pre_count", int'(count_o), 2);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 12 + i, 1'b1, 1'b0);
            check("pp_count", int'(count_o), 2);
        end

        // Flush at count 3 with simultaneous push and pop.
        step(1'b1, 22, 1'b0, 1'b0);
        check("preflush_count", int'(count_o), 3);
        step(1'b1, 9, 1'b1, 1'b1);
        check("flush_count", int'(count_o), 0);
        check("flush_valid", int'(valid_o), 0);
        check("flush_full",  int'(full_o),  0);

        // Pops while empty are ignored.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 1'b1, 1'b0);
            check("empty_pop_count", int'(count_o), 0);
            check("empty_pop_valid", int'(valid_o), 0);
        end
        step(1'b1, 7, 1'b0, 1'b0);
        check("push7_count", int'(count_o), 1);
        check("push7_valid", int'(valid_o), 1);
        check("push7_rob",   int'(data_out.rob_id), 7);
        step(1'b0, 0, 1'b1, 1'b0);
        check("pop7_count", int'(count_o), 0);

`ifdef ISSUE_DIV_FIFO_EMPTY_BYPASS_EN
        drive(1'b1, 'h12, 1'b1, 1'b0);
        #1;
        check("byp_valid", int'(valid_o), 1);
        check("byp_rob",   int'(data_out.rob_id), 'h12);
        @(posedge clk);
        commit();
        check("byp_count", int'(count_o), 0);
        drive(1'b1, 'h12, 1'b0, 1'b0);
        #1;
        check("byp_nopop_valid", int'(valid_o), 1);
        @(posedge clk);
        commit();
        model_cnt = 1;
        check("byp_nopop_count", int'(count_o), 1);
`else
        drive(1'b1, 'h12, 1'b0, 1'b0);
        #1;
        check("nobyp_valid", int'(valid_o), 0);
        @(posedge clk);
        commit();
        model_cnt = 1;
        check("nobyp_count", int'(count_o), 1);
`endif
        step(1'b0, 0, 1'b1, 1'b0);
        check("final_count", int'(count_o), 0);
        check("scoreboard_empty", exp_q.size(), 0);

        // Asynchronous reset mid-cycle.
        step(1'b1, 30, 1'b0, 1'b0);
        step(1'b1, 31, 1'b0, 1'b0);
        check("prerst_count", int'(count_o), 2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", int'(count_o), 0);
        check("async_rst_valid", int'(valid_o), 0);
        exp_q.delete();
        model_cnt = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("postrst_count", int'(count_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_div_fifo.md
Name: issue_div_fifo

Overview:
- Show-ahead FIFO between the issue stage's div-path selector and execute_div.
- Buffers issue_execute_pack_t entries pushed by issue and presents the head entry to execute_div as issue_div_fifo_data_out/_valid.
- execute_div consumes entries through issue_div_fifo_pop.
- Commit-stage flush discards all buffered entries.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy count (derived, not overridable).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- issue_div_fifo_data_in  input  issue_execute_pack_t  entry from issue.
- issue_div_fifo_push  input  1  push request from issue.
- issue_div_fifo_full  output  1  no free entry (count == DEPTH).
- issue_div_fifo_data_out  output  issue_execute_pack_t  head entry (show-ahead).
- issue_div_fifo_data_out_valid  output  1  head entry valid (count != 0).
- issue_div_fifo_pop  input  1  head consumed by execute_div.
- issue_div_fifo_count  output  CNT_W  current occupancy.
- commit_feedback_pack  input  commit_feedback_pack_t  only .enable and .flush are used.

Behaviour:
- Storage and pointers:
  - Storage: DEPTH-entry register array.
  - Pointers: rptr/wptr, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - count = wptr - rptr; full = (count == DEPTH); data_out_valid = (count != 0).
- Reset (async, rst=1):
  - rptr = wptr = 0, so count = 0, full = 0, data_out_valid = 0.
  - Storage contents are don't-care.
  - data_out = entry at rptr (don't-care while valid = 0).
- Output timing: data_out is combinational from storage[rptr[low bits]]; zero-cycle read latency. Push-to-visible latency is 1 cycle.
- flush = commit_feedback_pack.enable & commit_feedback_pack.flush.
- Priority per cycle: flush > (push, pop).
  - flush=1: rptr <= 0, wptr <= 0; push and pop that cycle are ignored.
  - Push accepted iff push & !full: storage[wptr] <= data_in, wptr <= wptr + 1.
  - Pop accepted iff pop & data_out_valid: rptr <= rptr + 1.
  - Push and pop are independent and may both be accepted in the same cycle; count is then unchanged.
- Boundary conditions:
  - Push while full is dropped, even if pop is also asserted that cycle; full is registered-state based, with no pop-to-push combinational path. Issue must gate push with !full.
  - Pop while empty is ignored; pointers are unchanged.
  - Pointer wrap: low bits wrap modulo DEPTH and the wrap bit toggles, so full and empty are distinguishable at equal low bits.
- Flush visibility: flush clears on the next edge. During the flush cycle, data_out_valid still reflects pre-flush state; execute_div independently suppresses work on flush.
- Reset asserted mid-operation clears state immediately (asynchronously), independent of clk.
- No combinational path from data_in or push to any output (base build).

Optional Feature:
- Macro: ISSUE_DIV_FIFO_EMPTY_BYPASS_EN.
- Defined, when count == 0 and push is asserted (flush=0):
  - data_out = data_in and data_out_valid = 1 combinationally in the same cycle.
  - If pop is also asserted that cycle, the entry is consumed without being written; pointers are unchanged.
  - If pop is not asserted, the entry is stored normally.
- Undefined: no bypass; an entry is first visible the cycle after push. Default is undefined.

Test Plan:
- Reset then idle, no push/pop for 5 cycles -> count=0, data_out_valid=0, full=0 every cycle.
- Push packs with rob_id 1,2,3,4 on consecutive cycles (DEPTH=4), no pop -> full=1 after the 4th edge. A 5th push (rob_id 5) is dropped. Pop 4 times -> data_out.rob_id reads 1,2,3,4 in order, then valid=0.
- Simultaneous push+pop at count=2 for 10 cycles, rob_ids incrementing -> count stays 2, output order matches input order across pointer wrap (rptr passes index 3 -> 0 at least twice).
- At count=3, assert commit_feedback_pack.enable=1, flush=1 together with push (rob_id 9) and pop -> next cycle count=0, valid=0. rob_id 9 never appears on data_out.
- Pop with count=0 for 3 cycles, then push rob_id 7 -> pointers unchanged during the empty pops. rob_id 7 appears on data_out the next cycle with count=1.
- With ISSUE_DIV_FIFO_EMPTY_BYPASS_EN: push rob_id 0x12 + pop while empty -> data_out.rob_id=0x12 and valid=1 in the same cycle, count stays 0 after the edge. Repeat without pop -> count=1 after the edge.
